// File: rtl/vga_scene_renderer_if.sv
// Bundle of scan position, game state and RGB output between the sync/game logic and the renderer.
// master drives the scan and game state, slave (the renderer) returns colour and frame_start.
interface vga_scene_renderer_if #(
  parameter int R_W = 3,
  parameter int G_W = 3,
  parameter int B_W = 2
);
  logic [9:0]     counter_x;
  logic [9:0]     counter_y;
  logic [9:0]     ball_loc_x;
  logic [9:0]     ball_loc_y;
  logic [9:0]     left_paddle_loc;
  logic [9:0]     right_paddle_loc;
  logic [3:0]     left_score;
  logic [3:0]     right_score;
  logic           goal_pulse;
  logic           goal_side;
  logic           frame_start;
  logic [R_W-1:0] r;
  logic [G_W-1:0] g;
  logic [B_W-1:0] b;

  modport master (
    output counter_x, counter_y, ball_loc_x, ball_loc_y,
    output left_paddle_loc, right_paddle_loc, left_score, right_score,
    output goal_pulse, goal_side,
    input  frame_start, r, g, b
  );

  modport slave (
    input  counter_x, counter_y, ball_loc_x, ball_loc_y,
    input  left_paddle_loc, right_paddle_loc, left_score, right_score,
    input  goal_pulse, goal_side,
    output frame_start, r, g, b
  );
endinterface

// File: rtl/vga_scene_renderer.sv
// Pong scene renderer: per-frame shadowed game state, 2-stage hit/colour pipeline, goal-flash FSM.
// Define SCORE_PIPS_EN to render score pips; without it the scores are ignored.
module vga_scene_renderer #(
  parameter int          R_W                = 3,
  parameter int          G_W                = 3,
  parameter int          B_W                = 2,
  parameter int          H_ACTIVE           = 640,
  parameter int          V_ACTIVE           = 480,
  parameter int          FIELD_X_BEGIN      = 16,
  parameter int          FIELD_X_END        = 623,
  parameter int          FIELD_Y_BEGIN      = 16,
  parameter int          FIELD_Y_END        = 463,
  parameter int          BALL_RADIUS        = 4,
  parameter int          PADDLE_RADIUS      = 32,
  parameter int          PADDLE_THICKNESS   = 8,
  parameter int          LEFT_PADDLE_BEGIN  = 40,
  parameter int          RIGHT_PADDLE_BEGIN = 592,
  parameter int          SCORE_Y            = 4,
  parameter int          LEFT_SCORE_X       = 24,
  parameter int          RIGHT_SCORE_X      = 615,
  parameter int          FLASH_FRAMES       = 32,
  parameter logic [23:0] BORDER_RGB         = 24'h008040,
  parameter logic [23:0] BALL_RGB           = 24'hFFFFFF,
  parameter logic [23:0] LPAD_RGB           = 24'hFF0000,
  parameter logic [23:0] RPAD_RGB           = 24'hC06080,
  parameter logic [23:0] PIP_RGB            = 24'hFFFF00,
  parameter logic [23:0] FLASH_RGB          = 24'hFFFFFF
) (
  input logic                clk,
  input logic                reset,
  vga_scene_renderer_if.slave bus
);

  localparam int CNT_W = (FLASH_FRAMES < 8) ? 3 : $clog2(FLASH_FRAMES + 1);

  localparam logic [9:0]  BALL_X0  = 10'((FIELD_X_BEGIN + FIELD_X_END) / 2);
  localparam logic [9:0]  FIELD_YC = 10'((FIELD_Y_BEGIN + FIELD_Y_END) / 2);
  localparam logic [10:0] BALL_R   = 11'(BALL_RADIUS);
  localparam logic [10:0] PAD_R    = 11'(PADDLE_RADIUS);
  localparam logic [10:0] LPAD_X0  = 11'(LEFT_PADDLE_BEGIN);
  localparam logic [10:0] LPAD_X1  = 11'(LEFT_PADDLE_BEGIN + PADDLE_THICKNESS - 1);
  localparam logic [10:0] RPAD_X0  = 11'(RIGHT_PADDLE_BEGIN);
  localparam logic [10:0] RPAD_X1  = 11'(RIGHT_PADDLE_BEGIN + PADDLE_THICKNESS - 1);
  localparam logic [10:0] HALF_X   = 11'(H_ACTIVE / 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FLASH = 2'd2
  } state_t;

  // Lower bound saturates at zero so objects near the left/top edge never wrap.
  function automatic logic [10:0] lo_bound(input logic [9:0] loc, input logic [10:0] rad);
    logic [10:0] l;
    l = {1'b0, loc};
    return (l < rad) ? 11'd0 : (l - rad);
  endfunction

  function automatic logic [10:0] hi_bound(input logic [9:0] loc, input logic [10:0] rad);
    return {1'b0, loc} + rad;
  endfunction

  function automatic logic in_span(input logic [10:0] v, input logic [10:0] lo,
                                   input logic [10:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  logic [9:0] sh_ball_x;
  logic [9:0] sh_ball_y;
  logic [9:0] sh_lpad;
  logic [9:0] sh_rpad;
  logic       frame_start_p1;
  logic       latch;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               side_q, side_d;
  logic               flash_on;

  logic [10:0] x11, y11;
  logic        ball_hit, lpad_hit, rpad_hit, pip_hit, border_hit, flash_hit;

  logic [9:0]  x_p1, y_p1;
  logic        vld_p1;
  logic        ball_p1, lpad_p1, rpad_p1, pip_p1, border_p1, flash_p1;
  logic [23:0] rgb_sel;

  logic [R_W-1:0] r_p2;
  logic [G_W-1:0] g_p2;
  logic [B_W-1:0] b_p2;

  assign latch = (bus.counter_x == 10'd0) && (bus.counter_y == 10'(V_ACTIVE));
  assign x11   = {1'b0, bus.counter_x};
  assign y11   = {1'b0, bus.counter_y};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_ball_x      <= BALL_X0;
      sh_ball_y      <= FIELD_YC;
      sh_lpad        <= FIELD_YC;
      sh_rpad        <= FIELD_YC;
      frame_start_p1 <= 1'b0;
    end else begin
      frame_start_p1 <= latch;
      if (latch) begin
        sh_ball_x <= bus.ball_loc_x;
        sh_ball_y <= bus.ball_loc_y;
        sh_lpad   <= bus.left_paddle_loc;
        sh_rpad   <= bus.right_paddle_loc;
      end
    end
  end

`ifdef SCORE_PIPS_EN
  logic [3:0] sh_lscore, sh_rscore;
  logic [9:0] loff, roff;
  logic       pip_row;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_lscore <= 4'd0;
      sh_rscore <= 4'd0;
    end else if (latch) begin
      sh_lscore <= bus.left_score;
      sh_rscore <= bus.right_score;
    end
  end

  // Pip n occupies offsets 8n..8n+5; offsets past 127 would alias back onto pip 0.
  function automatic logic pip_lit(input logic [9:0] off, input logic [3:0] score);
    return (off[9:7] == 3'd0) && (off[6:3] < score) && (off[2:0] < 3'd6);
  endfunction

  assign loff    = bus.counter_x - 10'(LEFT_SCORE_X);
  assign roff    = 10'(RIGHT_SCORE_X) - bus.counter_x;
  assign pip_row = (y11 >= 11'(SCORE_Y)) && (y11 <= 11'(SCORE_Y + 3));
  assign pip_hit = pip_row &&
                   (((x11 >= 11'(LEFT_SCORE_X)) && pip_lit(loff, sh_lscore)) ||
                    ((x11 <= 11'(RIGHT_SCORE_X)) && pip_lit(roff, sh_rscore)));
`else
  logic unused_pip_cfg;
  assign unused_pip_cfg = ^{bus.left_score, bus.right_score,
                            10'(SCORE_Y), 10'(LEFT_SCORE_X), 10'(RIGHT_SCORE_X)};
  assign pip_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      side_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      side_q  <= side_d;
    end
  end

  // A goal pulse always wins over a simultaneous frame latch and restarts the sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    side_d  = side_q;
    if (bus.goal_pulse) begin
      state_d = ARMED;
      side_d  = bus.goal_side;
    end else if (latch) begin
      case (state_q)
        ARMED: begin
          if (FLASH_FRAMES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = FLASH;
            cnt_d   = CNT_W'(FLASH_FRAMES);
          end
        end
        FLASH: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  assign flash_on = (state_q == FLASH) && cnt_q[2];

  assign ball_hit   = in_span(x11, lo_bound(sh_ball_x, BALL_R), hi_bound(sh_ball_x, BALL_R)) &&
                      in_span(y11, lo_bound(sh_ball_y, BALL_R), hi_bound(sh_ball_y, BALL_R));
  assign lpad_hit   = in_span(x11, LPAD_X0, LPAD_X1) &&
                      in_span(y11, lo_bound(sh_lpad, PAD_R), hi_bound(sh_lpad, PAD_R));
  assign rpad_hit   = in_span(x11, RPAD_X0, RPAD_X1) &&
                      in_span(y11, lo_bound(sh_rpad, PAD_R), hi_bound(sh_rpad, PAD_R));
  assign border_hit = (x11 < 11'(FIELD_X_BEGIN)) || (x11 > 11'(FIELD_X_END)) ||
                      (y11 < 11'(FIELD_Y_BEGIN)) || (y11 > 11'(FIELD_Y_END));
  assign flash_hit  = flash_on && (side_q ? (x11 >= HALF_X) : (x11 < HALF_X));

  // Stage 1: coordinate and hit flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vld_p1 <= 1'b0;
    else        vld_p1 <= 1'b1;
  end

  always_ff @(posedge clk) begin
    x_p1      <= bus.counter_x;
    y_p1      <= bus.counter_y;
    ball_p1   <= ball_hit;
    lpad_p1   <= lpad_hit;
    rpad_p1   <= rpad_hit;
    pip_p1    <= pip_hit;
    border_p1 <= border_hit;
    flash_p1  <= flash_hit;
  end

  always_comb begin
    rgb_sel = 24'h000000;
    if (!vld_p1 || (x_p1 >= 10'(H_ACTIVE)) || (y_p1 >= 10'(V_ACTIVE))) begin
      rgb_sel = 24'h000000;
    end else if (rpad_p1) begin
      rgb_sel = RPAD_RGB;
    end else if (lpad_p1) begin
      rgb_sel = LPAD_RGB;
    end else if (ball_p1) begin
      rgb_sel = BALL_RGB;
    end else if (pip_p1) begin
      rgb_sel = PIP_RGB;
    end else if (border_p1) begin
      rgb_sel = flash_p1 ? FLASH_RGB : BORDER_RGB;
    end
  end

  // Stage 2: colour register, top bits of each 8-bit channel
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_p2 <= '0;
      g_p2 <= '0;
      b_p2 <= '0;
    end else begin
      r_p2 <= rgb_sel[23 -: R_W];
      g_p2 <= rgb_sel[15 -: G_W];
      b_p2 <= rgb_sel[7 -: B_W];
    end
  end

  assign bus.r           = r_p2;
  assign bus.g           = g_p2;
  assign bus.b           = b_p2;
  assign bus.frame_start = frame_start_p1;

endmodule

// File: doc/vga_scene_renderer.md
Name: vga_scene_renderer

Overview:
- Parametrised successor to the pong pixel colour generator.
- Converts the VGA scan position and game state into RGB through a 2-stage pipeline.
- Adds per-frame shadowing of game state (no tearing), underflow-safe bounds, configurable colour depth and colours, score pips, and a goal-flash state machine.
- Sits between the sync generator/game logic and the DAC pins.

Parameters:
- R_W, 3: red output width (1..8).
- G_W, 3: green output width (1..8).
- B_W, 2: blue output width (1..8).
- H_ACTIVE, 640 / V_ACTIVE, 480: visible area.
- FIELD_X_BEGIN, 16 / FIELD_X_END, 623 / FIELD_Y_BEGIN, 16 / FIELD_Y_END, 463: playfield limits.
- BALL_RADIUS, 4 / PADDLE_RADIUS, 32 / PADDLE_THICKNESS, 8: object sizes in pixels.
- LEFT_PADDLE_BEGIN, 40 / RIGHT_PADDLE_BEGIN, 592: paddle left x.
- SCORE_Y, 4 / LEFT_SCORE_X, 24 / RIGHT_SCORE_X, 615: pip row top; left pip origin; right pip origin (rightmost pixel).
- FLASH_FRAMES, 32: frames of goal flash; 0 disables flashing.
- BORDER_RGB, 24'h008040: border colour (8 bits per channel, RRGGBB).
- BALL_RGB, 24'hFFFFFF: ball colour.
- LPAD_RGB, 24'hFF0000: left paddle colour.
- RPAD_RGB, 24'hC06080: right paddle colour.
- PIP_RGB, 24'hFFFF00: score pip colour.
- FLASH_RGB, 24'hFFFFFF: goal-flash border colour.

Ports:
- clk  in  1  pixel clock (25 MHz)
- reset  in  1  asynchronous, active-low reset
- counter_x  in  10  current scan column
- counter_y  in  10  current scan row
- ball_loc_x  in  10  ball centre x
- ball_loc_y  in  10  ball centre y
- left_paddle_loc  in  10  left paddle centre y
- right_paddle_loc  in  10  right paddle centre y
- left_score  in  4  left score
- right_score  in  4  right score
- goal_pulse  in  1  one-cycle goal event
- goal_side  in  1  scoring side: 0 left, 1 right; sampled with goal_pulse
- frame_start  out  1  one-cycle pulse at the shadow-latch cycle
- r  out  R_W  red
- g  out  G_W  green
- b  out  B_W  blue

Behaviour:
- Reset (reset low, asynchronous):
  - r, g, b, frame_start = 0.
  - Shadows: ball = ((FIELD_X_BEGIN+FIELD_X_END)/2, (FIELD_Y_BEGIN+FIELD_Y_END)/2); paddles = vertical field centre; scores = 0.
  - FSM = IDLE; flash counter = 0.
- Shadow latch:
  - Fires when counter_x==0 && counter_y==V_ACTIVE.
  - All position and score inputs are copied into shadows that cycle.
  - frame_start is high on the following cycle.
  - All rendering uses shadows only; input changes mid-frame are invisible until the next latch.
- Pipeline and latency:
  - Stage 1 registers the coordinate and all hit flags.
  - Stage 2 registers the priority-muxed colour.
  - Latency: colour for (x,y) appears exactly 2 clk after that coordinate is presented.
- Bounds arithmetic:
  - Computed at 11 bits.
  - Lower bound = (loc < radius) ? 0 : loc-radius. Upper bound = loc+radius, with no truncation.
  - Ball at x=2, radius 4 covers x 0..6; it must not wrap.
- Colour conversion: each channel output is the top *_W bits of the corresponding 8-bit parameter byte.
- Priority, highest first:
  1. Blanking (x>=H_ACTIVE or y>=V_ACTIVE): black.
  2. Right paddle.
  3. Left paddle.
  4. Ball.
  5. Score pip.
  6. Border (outside the field limits, inclusive limits are field): BORDER_RGB, or FLASH_RGB when flash is active on that half.
  7. Background: black.
- Score pips:
  - Rows SCORE_Y..SCORE_Y+3; pitch 8 px, 6 px lit, 2 px dark.
  - Left: off = x-LEFT_SCORE_X (x >= origin). Lit when off[6:3] < left_score and off[2:0] < 6.
  - Right: off = RIGHT_SCORE_X-x (x <= origin), same rule using right_score.
  - Score 0 draws nothing; score 15 draws 15 pips.
- Goal FSM:
  - IDLE: on goal_pulse, latch side, go to ARMED.
  - ARMED: at shadow latch, load count = FLASH_FRAMES and go to FLASH; if FLASH_FRAMES==0, go to IDLE.
  - FLASH: each shadow latch decrements count; at count==0 go to IDLE.
  - Flash active when in FLASH and count[2]==1 (toggles every 4 frames). Only border pixels with x < H_ACTIVE/2 (side 0) or x >= H_ACTIVE/2 (side 1) use FLASH_RGB.
  - goal_pulse in ARMED or FLASH: relatch side, go to ARMED (restart).
  - goal_pulse coinciding with shadow latch: the pulse wins (ARMED).
- Reset mid-frame: outputs clear at once. Rendering resumes from reset shadows after the pipeline refills (2 clk), with no wait for a latch.

Optional Feature:
- Macro SCORE_PIPS_EN.
- Defined: pips rendered as above.
- Undefined: no pip logic. left_score/right_score are ignored and not shadowed; pip pixels show border colour.

Test Plan:
- Reset low mid-line -> r/g/b=0 immediately. After release with x=320,y=240: 2 clk later output = BALL_RGB top bits (3'b111,3'b111,2'b11).
- Ball input changed to (100,100) mid-frame -> pixel (100,100) stays background until latch at (0,480). frame_start pulses; pixel (100,100) is ball in the next frame.
- Ball at x=2,y=200, scan x=0 and x=1020 at y=200 -> x=0 ball colour; x=1020 not ball (no wrap).
- Ball overlapping left paddle at (44,240) -> LPAD_RGB (3'b111,0,0); blanking x=700 -> black despite any overlap.
- left_score=3 (SCORE_PIPS_EN defined) -> y=5: x=24..29 pip, x=30..31 border, x=40..45 pip, x=48 border.
- goal_pulse side=1, FLASH_FRAMES=32 -> ARMED; next latch count=32. Frames with count[2]=1: right-half border = FLASH_RGB, left-half border normal. After 32 latches, IDLE. A second pulse mid-flash restarts the flash.
